// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core; this slice carries the SQI
// master's state encoding and command opcodes.
package idli_pkg;

  typedef logic [1:0]  ctr_t;
  typedef logic [3:0]  slice_t;
  typedef logic [15:0] data_t;

  typedef enum logic [2:0] {
    SQI_IDLE,
    SQI_GAP,
    SQI_CMD,
    SQI_ADDR,
    SQI_DUMMY,
    SQI_DATA
  } sqi_state_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  // Command byte followed by the 24b byte address of a 16b word address.
  function automatic logic [31:0] sqi_preamble(input logic [7:0] cmd,
                                               input data_t      addr);
    return {cmd, 7'b0, addr, 1'b0};
  endfunction

endpackage

// File: rtl/idli_sqi_m.sv
// SQI master: issues command/address/turnaround to the serial memory, then
// streams data a nibble per GCK, assembling 16b read words for decode.
module idli_sqi_m
  import idli_pkg::*;
#(
  parameter logic [7:0]  CMD_READ  = SQI_CMD_READ,
  parameter logic [7:0]  CMD_WRITE = SQI_CMD_WRITE,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic   i_sq_gck,
  input  logic   i_sq_rst_n,
  input  ctr_t   i_sq_ctr,
  input  logic   i_sq_redir,
  input  data_t  i_sq_addr,
  input  logic   i_sq_wr,
  input  slice_t i_sq_wdata,
  input  slice_t i_sq_sio,
  output slice_t o_sq_sio,
  output logic   o_sq_sio_oe,
  output logic   o_sq_cs_n,
  output logic   o_sq_sck_en,
  output data_t  o_sq_enc,
  output logic   o_sq_enc_vld,
  output logic   o_sq_busy
);

  // Last GAP cycle index that satisfies the chip-select high time.
  localparam logic [3:0] GAP_LAST = (CS_GAP > 1) ? 4'(CS_GAP - 1) : 4'd0;

  sqi_state_t  state, state_next;
  logic [3:0]  nib_cnt;
  logic [31:0] shift;
  logic        wr_q;
  slice_t      slot0, slot1, slot2;
  logic        redir_ok;
  logic        in_pre;

  assign redir_ok = i_sq_redir && (i_sq_ctr == 2'd3);
  assign in_pre   = (state == SQI_GAP) || (state == SQI_CMD) ||
                    (state == SQI_ADDR) || (state == SQI_DUMMY);

  always_comb begin
    state_next = state;
    unique case (state)
      SQI_IDLE:  if (redir_ok) state_next = SQI_GAP;
      // Alignment makes DATA start at ctr==0 for both reads and writes.
      SQI_GAP:   if (nib_cnt >= GAP_LAST &&
                     (wr_q ? (i_sq_ctr == 2'd3) : (i_sq_ctr == 2'd1)))
                   state_next = SQI_CMD;
      SQI_CMD:   if (nib_cnt == 4'd1) state_next = SQI_ADDR;
      SQI_ADDR:  if (nib_cnt == 4'd5) state_next = wr_q ? SQI_DATA : SQI_DUMMY;
      SQI_DUMMY: if (nib_cnt == 4'd1) state_next = SQI_DATA;
      SQI_DATA:  if (redir_ok) state_next = SQI_GAP;
      default:   state_next = SQI_IDLE;
    endcase
  end

  always_ff @(posedge i_sq_gck) begin
    if (!i_sq_rst_n) begin
      state   <= SQI_IDLE;
      nib_cnt <= '0;
      shift   <= '0;
      wr_q    <= 1'b0;
      slot0   <= '0;
      slot1   <= '0;
      slot2   <= '0;
    end else begin
      state <= state_next;

      if (state_next != state)
        nib_cnt <= '0;
      else if (in_pre)
        nib_cnt <= nib_cnt + 4'd1;

      if (redir_ok && (state == SQI_IDLE || state == SQI_DATA)) begin
        shift <= sqi_preamble(i_sq_wr ? CMD_WRITE : CMD_READ, i_sq_addr);
        wr_q  <= i_sq_wr;
      end else if (state == SQI_CMD || state == SQI_ADDR) begin
        shift <= {shift[27:0], 4'h0};
      end

      if (state == SQI_DATA && !wr_q) begin
        unique case (i_sq_ctr)
          2'd0:    slot0 <= i_sq_sio;
          2'd1:    slot1 <= i_sq_sio;
          2'd2:    slot2 <= i_sq_sio;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_sq_sio     = '0;
    o_sq_sio_oe  = 1'b0;
    o_sq_cs_n    = 1'b1;
    o_sq_sck_en  = 1'b0;
    o_sq_enc_vld = 1'b0;
    o_sq_busy    = in_pre;
    unique case (state)
      SQI_CMD, SQI_ADDR: begin
        o_sq_sio    = shift[31:28];
        o_sq_sio_oe = 1'b1;
        o_sq_cs_n   = 1'b0;
        o_sq_sck_en = 1'b1;
      end
      SQI_DUMMY: begin
        o_sq_cs_n   = 1'b0;
        o_sq_sck_en = 1'b1;
      end
      SQI_DATA: begin
        o_sq_cs_n   = 1'b0;
        o_sq_sck_en = 1'b1;
        if (wr_q) begin
          o_sq_sio    = i_sq_wdata;
          o_sq_sio_oe = 1'b1;
        end else begin
          o_sq_enc_vld = (i_sq_ctr == 2'd3);
        end
      end
      default: ;
    endcase
  end

  assign o_sq_enc = {slot0, slot1, slot2, i_sq_sio};

endmodule

// File: tb/tb_idli_sqi_m.sv
// Directed bench for idli_sqi_m: preamble nibbles, read assembly, write
// forwarding, ignored/back-to-back redirects and synchronous reset.
module tb_idli_sqi_m;
  import idli_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  ctr_t   ctr;
  logic   redir;
  data_t  addr;
  logic   wr;
  slice_t wdata;
  slice_t sio_in;
  slice_t sio_out;
  logic   oe, cs_n, sck_en, vld, busy;
  data_t  enc;

  int compared   = 0;
  int mismatched = 0;

  // Status vector {cs_n, oe, sck_en, busy, vld}
  localparam logic [4:0] ST_IDLE  = 5'b10000;
  localparam logic [4:0] ST_GAP   = 5'b10010;
  localparam logic [4:0] ST_PRE   = 5'b01110;
  localparam logic [4:0] ST_DUMMY = 5'b00110;
  localparam logic [4:0] ST_RD    = 5'b00100;
  localparam logic [4:0] ST_RDV   = 5'b00101;
  localparam logic [4:0] ST_WR    = 5'b01100;

  logic [4:0] st;
  assign st = {cs_n, oe, sck_en, busy, vld};

  idli_sqi_m #(.CMD_READ(8'h03), .CMD_WRITE(8'h02), .CS_GAP(2)) dut (
    .i_sq_gck    (clk),
    .i_sq_rst_n  (rst_n),
    .i_sq_ctr    (ctr),
    .i_sq_redir  (redir),
    .i_sq_addr   (addr),
    .i_sq_wr     (wr),
    .i_sq_wdata  (wdata),
    .i_sq_sio    (sio_in),
    .o_sq_sio    (sio_out),
    .o_sq_sio_oe (oe),
    .o_sq_cs_n   (cs_n),
    .o_sq_sck_en (sck_en),
    .o_sq_enc    (enc),
    .o_sq_enc_vld(vld),
    .o_sq_busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    ctr = ctr + 2'd1;
  endtask

  task automatic wait_ctr(input ctr_t k);
    for (int n = 0; n < 4 && ctr != k; n++) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    compared++;
    if (st !== ST_IDLE || sio_out !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_state st=%b sio=%h want st=%b sio=0", st, sio_out, ST_IDLE);
    end
    rst_n = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    compared++;
    if (st !== ST_IDLE) begin
      mismatched++;
      $display("FAIL reset_idle st=%b want %b", st, ST_IDLE);
    end
  endtask

  task automatic test_read_preamble();
    logic [3:0] pre [8];
    pre = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};
    wait_ctr(2'd3);
    redir = 1'b1; addr = 16'h1234; wr = 1'b0;
    @(negedge clk);
    compared++;
    if (st !== ST_IDLE) begin
      mismatched++;
      $display("FAIL rd_redir_cycle st=%b want %b", st, ST_IDLE);
    end
    cyc();
    redir = 1'b0; addr = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (st !== ST_GAP) begin
        mismatched++;
        $display("FAIL rd_gap[%0d] st=%b want %b", i, st, ST_GAP);
      end
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      compared++;
      if (st !== ST_PRE || sio_out !== pre[i]) begin
        mismatched++;
        $display("FAIL rd_pre[%0d] st=%b sio=%h want st=%b sio=%h", i, st, sio_out, ST_PRE, pre[i]);
      end
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (st !== ST_DUMMY) begin
        mismatched++;
        $display("FAIL rd_dummy[%0d] st=%b want %b", i, st, ST_DUMMY);
      end
      cyc();
    end
  endtask

  task automatic test_read_stream();
    logic [3:0] seq [8];
    data_t      word [2];
    seq  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
    word = '{16'hABCD, 16'h1234};
    for (int i = 0; i < 8; i++) begin
      sio_in = seq[i];
      @(negedge clk);
      compared++;
      if (i % 4 == 3) begin
        if (st !== ST_RDV || enc !== word[i/4]) begin
          mismatched++;
          $display("FAIL rd_word[%0d] st=%b enc=%h want st=%b enc=%h", i/4, st, enc, ST_RDV, word[i/4]);
        end
      end else if (st !== ST_RD) begin
        mismatched++;
        $display("FAIL rd_slot[%0d] st=%b want %b", i, st, ST_RD);
      end
      cyc();
    end
  endtask

  task automatic test_redir_ignored_data();
    logic [3:0] seq [4];
    seq = '{4'h5, 4'h6, 4'h7, 4'h8};
    for (int i = 0; i < 4; i++) begin
      sio_in = seq[i];
      redir  = (i == 1);
      addr   = 16'hFFFF;
      wr     = 1'b1;
      @(negedge clk);
      compared++;
      if (st !== ((i == 3) ? ST_RDV : ST_RD) || (i == 3 && enc !== 16'h5678)) begin
        mismatched++;
        $display("FAIL ign_data[%0d] st=%b enc=%h want enc=5678", i, st, enc);
      end
      cyc();
    end
    redir = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [4];
    logic [3:0] pre [8];
    int         gap;
    seq = '{4'h9, 4'hA, 4'hB, 4'hC};
    pre = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
    for (int i = 0; i < 4; i++) begin
      sio_in = seq[i];
      if (i == 3) begin
        redir = 1'b1; addr = 16'h0001; wr = 1'b1;
      end
      @(negedge clk);
      if (i == 3) begin
        compared++;
        if (st !== ST_RDV || enc !== 16'h9ABC) begin
          mismatched++;
          $display("FAIL b2b_last_word st=%b enc=%h want st=%b enc=9abc", st, enc, ST_RDV);
        end
      end
      cyc();
    end
    redir = 1'b0; addr = 16'h0000; wr = 1'b0;
    gap = 0;
    @(negedge clk);
    while (cs_n === 1'b1 && gap < 12) begin
      gap++;
      cyc();
      @(negedge clk);
    end
    compared++;
    if (gap != 4 || ctr !== 2'd0) begin
      mismatched++;
      $display("FAIL b2b_gap cycles=%0d cmd_ctr=%0d want cycles=4 cmd_ctr=0", gap, ctr);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        cyc();
        redir = (i == 3);
        addr  = 16'hFFFF;
        wr    = 1'b0;
        @(negedge clk);
      end
      compared++;
      if (st !== ST_PRE || sio_out !== pre[i]) begin
        mismatched++;
        $display("FAIL wr_pre[%0d] st=%b sio=%h want st=%b sio=%h", i, st, sio_out, ST_PRE, pre[i]);
      end
    end
    cyc();
    redir = 1'b0;
  endtask

  task automatic test_write_data();
    logic [3:0] seq [4];
    seq = '{4'h5, 4'h6, 4'h7, 4'h8};
    for (int i = 0; i < 4; i++) begin
      wdata = seq[i];
      @(negedge clk);
      compared++;
      if (st !== ST_WR || sio_out !== seq[i]) begin
        mismatched++;
        $display("FAIL wr_data[%0d] st=%b sio=%h want st=%b sio=%h", i, st, sio_out, ST_WR, seq[i]);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] pre [8];
    pre = '{4'h0, 4'h3, 4'h0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hE};
    rst_n = 1'b0;
    wdata = 4'h3;
    @(negedge clk);
    compared++;
    if (st !== ST_WR || sio_out !== 4'h3) begin
      mismatched++;
      $display("FAIL rst_sync st=%b sio=%h want st=%b sio=3", st, sio_out, ST_WR);
    end
    cyc();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      compared++;
      if (st !== ST_IDLE || sio_out !== 4'h0) begin
        mismatched++;
        $display("FAIL rst_hold[%0d] st=%b sio=%h want st=%b sio=0", i, st, sio_out, ST_IDLE);
      end
      cyc();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if (st !== ST_IDLE) begin
        mismatched++;
        $display("FAIL rst_quiet[%0d] st=%b want %b", i, st, ST_IDLE);
      end
      cyc();
    end
    wait_ctr(2'd3);
    redir = 1'b1; addr = 16'hFFFF; wr = 1'b0;
    cyc();
    redir = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      compared++;
      if (st !== ST_PRE || sio_out !== pre[i]) begin
        mismatched++;
        $display("FAIL top_pre[%0d] st=%b sio=%h want st=%b sio=%h", i, st, sio_out, ST_PRE, pre[i]);
      end
      cyc();
    end
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      sio_in = (i % 2 == 0) ? 4'h0 : 4'hF;
      @(negedge clk);
      if (i == 3) begin
        compared++;
        if (st !== ST_RDV || enc !== 16'h0F0F) begin
          mismatched++;
          $display("FAIL top_word st=%b enc=%h want st=%b enc=0f0f", st, enc, ST_RDV);
        end
      end
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ctr = 2'd0; redir = 1'b0; addr = '0; wr = 1'b0;
    wdata = '0; sio_in = '0;
    test_reset();
    test_read_preamble();
    test_read_stream();
    test_redir_ignored_data();
    test_back_to_back();
    test_write_data();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
